// File: rtl/fir_sweep_controller.sv
// Frequency-response sweep sequencer for the sig_gen -> FIR -> peak detector chain.
// Steps the FCW over a programmed set of points and streams (fcw, amplitude) results out.
module fir_sweep_controller #(
  parameter int SETTLE_PERIODS  = 4,
  parameter int MEASURE_PERIODS = 2,
  parameter int MAX_POINTS      = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic signed [15:0] fcw_start,
  input  logic signed [15:0] fcw_step,
  input  logic        [8:0]  num_points,
  input  logic               phase_wrap,
  input  logic signed [15:0] amplitude_in,
  output logic               enable,
  output logic signed [15:0] fcw,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic signed [15:0] res_fcw,
  output logic signed [15:0] res_amp,
  output logic               done,
  output logic signed [15:0] best_fcw,
  output logic signed [15:0] best_amp
);

  localparam int PW = $clog2(MAX_POINTS + 1);
  localparam int MAXP = (SETTLE_PERIODS > MEASURE_PERIODS) ? SETTLE_PERIODS : MEASURE_PERIODS;
  localparam int WW = $clog2(MAXP + 1);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    MEASURE,
    CAPTURE,
    REPORT,
    FINISH
  } state_t;

  state_t             state;
  logic signed [15:0] step_cfg;
  logic [PW-1:0]      num_cfg;
  logic [PW-1:0]      pt_cnt;
  logic [WW-1:0]      wrap_cnt;
  logic [PW-1:0]      num_clamped;

  assign num_clamped = (32'(num_points) > MAX_POINTS) ? PW'(MAX_POINTS) : PW'(num_points);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      enable    <= 1'b0;
      fcw       <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_fcw   <= '0;
      res_amp   <= '0;
      done      <= 1'b0;
      best_fcw  <= '0;
      best_amp  <= '0;
      step_cfg  <= '0;
      num_cfg   <= '0;
      pt_cnt    <= '0;
      wrap_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            step_cfg <= fcw_step;
            num_cfg  <= num_clamped;
            busy     <= 1'b1;
            if (num_clamped == '0) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              fcw      <= fcw_start;
              enable   <= 1'b1;
              best_amp <= 16'sh8000;
              best_fcw <= fcw_start;
              wrap_cnt <= '0;
              pt_cnt   <= '0;
              state    <= SETTLE;
            end
          end
        end
        SETTLE: begin
          if (phase_wrap) begin
            if (wrap_cnt == WW'(SETTLE_PERIODS - 1)) begin
              wrap_cnt <= '0;
              state    <= MEASURE;
            end else begin
              wrap_cnt <= wrap_cnt + WW'(1);
            end
          end
        end
        MEASURE: begin
          if (phase_wrap) begin
            if (wrap_cnt == WW'(MEASURE_PERIODS - 1)) begin
              wrap_cnt <= '0;
              state    <= CAPTURE;
            end else begin
              wrap_cnt <= wrap_cnt + WW'(1);
            end
          end
        end
        // Extra cycle lets the peak detector finish its update after the last wrap.
        CAPTURE: begin
          res_amp   <= amplitude_in;
          res_fcw   <= fcw;
          res_valid <= 1'b1;
          enable    <= 1'b0;
          state     <= REPORT;
        end
        REPORT: begin
          if (res_valid && res_ready) begin
            res_valid <= 1'b0;
            if (res_amp > best_amp) begin
              best_amp <= res_amp;
              best_fcw <= res_fcw;
            end
            pt_cnt <= pt_cnt + PW'(1);
            if (pt_cnt + PW'(1) == num_cfg) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              fcw      <= fcw + step_cfg;
              enable   <= 1'b1;
              wrap_cnt <= '0;
              state    <= SETTLE;
            end
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sweep_controller.sv
// Self-checking bench for fir_sweep_controller: event-level reference model compared every
// cycle, plus hand-computed literal expectations for the directed scenarios.
module tb_fir_sweep_controller;

  localparam int SETTLE_N  = 4;
  localparam int MEASURE_N = 2;
  localparam int MAX_PTS   = 256;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic signed [15:0] fcw_start = '0;
  logic signed [15:0] fcw_step = '0;
  logic        [8:0]  num_points = '0;
  logic               phase_wrap = 1'b0;
  logic signed [15:0] amplitude_in = '0;
  logic               res_ready = 1'b1;
  logic               enable, busy, res_valid, done;
  logic signed [15:0] fcw, res_fcw, res_amp, best_fcw, best_amp;

  always #5 clk = ~clk;

  fir_sweep_controller dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .fcw_start   (fcw_start),
    .fcw_step    (fcw_step),
    .num_points  (num_points),
    .phase_wrap  (phase_wrap),
    .amplitude_in(amplitude_in),
    .enable      (enable),
    .fcw         (fcw),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_fcw     (res_fcw),
    .res_amp     (res_amp),
    .done        (done),
    .best_fcw    (best_fcw),
    .best_amp    (best_amp)
  );

  int n_checks = 0;
  int n_failures = 0;
  logic chk_en = 1'b0;

  // Chain emulation state
  int tick = 0;
  int start_tick = 0;
  int wrap_period = 0;
  logic signed [15:0] amp_tab [8];

  // Statistics per sweep
  int done_count, hs_count, first_valid_cyc, done_cyc;
  logic valid_seen;
  logic signed [15:0] hs_fcw[$];

  // Reference model state
  logic m_busy, m_enable, m_valid, m_done, m_cap;
  logic signed [15:0] m_fcw, m_res_fcw, m_res_amp, m_best_fcw, m_best_amp, m_step;
  int m_point, m_n, m_wraps;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: a point finishes after SETTLE_N+MEASURE_N counted wraps, one capture cycle later.
  initial forever begin
    @(posedge clk);
    if (reset) begin
      m_busy = 0; m_enable = 0; m_valid = 0; m_done = 0; m_cap = 0;
      m_fcw = 0; m_res_fcw = 0; m_res_amp = 0; m_best_fcw = 0; m_best_amp = 0;
      m_point = 0; m_wraps = 0;
    end else if (m_done) begin
      m_done = 0;
      m_busy = 0;
    end else if (!m_busy) begin
      if (start) begin
        m_n = (int'(num_points) > MAX_PTS) ? MAX_PTS : int'(num_points);
        m_step = fcw_step;
        m_busy = 1;
        if (m_n == 0) m_done = 1;
        else begin
          m_fcw = fcw_start; m_enable = 1;
          m_best_amp = -16'sd32768; m_best_fcw = fcw_start;
          m_point = 0; m_wraps = 0;
        end
      end
    end else if (m_valid) begin
      if (res_ready) begin
        m_valid = 0;
        if (m_res_amp > m_best_amp) begin
          m_best_amp = m_res_amp;
          m_best_fcw = m_res_fcw;
        end
        m_point++;
        if (m_point == m_n) m_done = 1;
        else begin
          m_fcw = m_fcw + m_step;
          m_enable = 1;
          m_wraps = 0;
        end
      end
    end else if (m_cap) begin
      m_cap = 0;
      m_res_amp = amplitude_in;
      m_res_fcw = m_fcw;
      m_valid = 1;
      m_enable = 0;
    end else if (phase_wrap) begin
      m_wraps++;
      if (m_wraps == SETTLE_N + MEASURE_N) m_cap = 1;
    end
  end

  // Emulated sig_gen/peak detector: periodic wraps counted from the start cycle.
  initial forever begin
    @(posedge clk);
    #2;
    tick++;
    phase_wrap = (wrap_period > 0) && (((tick - start_tick) % wrap_period) == wrap_period - 1);
    amplitude_in = amp_tab[m_point % 8];
  end

  // Per-cycle comparison against the model plus sweep statistics.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      checkOutput("busy", busy, m_busy);
      checkOutput("enable", enable, m_enable);
      checkOutput("fcw", fcw, m_fcw);
      checkOutput("res_valid", res_valid, m_valid);
      checkOutput("res_fcw", res_fcw, m_res_fcw);
      checkOutput("res_amp", res_amp, m_res_amp);
      checkOutput("done", done, m_done);
      checkOutput("best_fcw", best_fcw, m_best_fcw);
      checkOutput("best_amp", best_amp, m_best_amp);
      if (res_valid && !valid_seen) begin
        valid_seen = 1;
        first_valid_cyc = tick - start_tick;
      end
      if (res_valid && res_ready) begin
        hs_count++;
        hs_fcw.push_back(res_fcw);
      end
      if (done) begin
        done_count++;
        done_cyc = tick - start_tick;
      end
    end
  end

  task automatic applyStimulus(input logic signed [15:0] fs, input logic signed [15:0] st,
                               input logic [8:0] n, input int period);
    @(posedge clk);
    #1;
    fcw_start = fs;
    fcw_step = st;
    num_points = n;
    wrap_period = period;
    start_tick = tick + 1;
    done_count = 0; hs_count = 0; first_valid_cyc = -1; done_cyc = -1;
    valid_seen = 0;
    hs_fcw.delete();
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask

  task automatic waitDone(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      #1;
      if (done_count != 0) break;
    end
    checkOutput("done_seen", 16'(done_count != 0), 16'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic waitHandshakes(input int target, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      #1;
      if (hs_count >= target) break;
    end
    checkOutput("hs_reached", 16'(hs_count >= target), 16'd1);
  endtask

  task automatic waitValid(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      #1;
      if (res_valid) break;
    end
    checkOutput("valid_seen", res_valid, 16'd1);
  endtask

  initial begin
    amp_tab[0] = 16'sd11;   amp_tab[1] = -16'sd40;  amp_tab[2] = 16'sd77;   amp_tab[3] = 16'sd5;
    amp_tab[4] = 16'sd200;  amp_tab[5] = -16'sd300; amp_tab[6] = 16'sd1234; amp_tab[7] = 16'sd0;
    done_count = 0; hs_count = 0; first_valid_cyc = -1; done_cyc = -1; valid_seen = 0;

    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    chk_en = 1;
    @(negedge clk);
    #1;
    checkOutput("rst_busy", busy, 16'd0);
    checkOutput("rst_enable", enable, 16'd0);
    checkOutput("rst_valid", res_valid, 16'd0);
    checkOutput("rst_fcw", fcw, 16'd0);
    checkOutput("rst_done", done, 16'd0);
    checkOutput("rst_best_amp", best_amp, 16'd0);

    // Abort mid-MEASURE on the second of four points.
    applyStimulus(16'sd10, 16'sd5, 9'd4, 1);
    waitHandshakes(1, 200);
    repeat (5) @(posedge clk);
    #1;
    reset = 1;
    @(posedge clk);
    #1;
    reset = 0;
    @(negedge clk);
    #1;
    checkOutput("abort_busy", busy, 16'd0);
    checkOutput("abort_enable", enable, 16'd0);
    checkOutput("abort_valid", res_valid, 16'd0);
    checkOutput("abort_fcw", fcw, 16'd0);
    repeat (10) @(negedge clk);
    #1;
    checkOutput("abort_no_done", 16'(done_count), 16'd0);
    applyStimulus(16'sd10, 16'sd5, 9'd4, 1);
    waitDone(500);
    checkOutput("fresh_hs", 16'(hs_count), 16'd4);

    // Basic sweep with a wrap every 20 cycles.
    applyStimulus(16'sd100, 16'sd50, 9'd3, 20);
    waitDone(3000);
    checkOutput("basic_hs", 16'(hs_count), 16'd3);
    checkOutput("basic_first_valid", 16'(first_valid_cyc), 16'd121);
    checkOutput("basic_done_cyc", 16'(done_cyc), 16'd362);
    checkOutput("basic_done_count", 16'(done_count), 16'd1);
    if (hs_fcw.size() == 3) begin
      checkOutput("basic_fcw0", hs_fcw[0], 16'd100);
      checkOutput("basic_fcw1", hs_fcw[1], 16'd150);
      checkOutput("basic_fcw2", hs_fcw[2], 16'd200);
    end

    // Backpressure: result must hold for 10 cycles while wraps keep arriving.
    res_ready = 0;
    applyStimulus(-16'sd200, 16'sd30, 9'd2, 3);
    waitValid(300);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      checkOutput("bp_valid", res_valid, 16'd1);
      checkOutput("bp_enable", enable, 16'd0);
      checkOutput("bp_fcw", fcw, 16'hFF38);
      checkOutput("bp_res_fcw", res_fcw, 16'hFF38);
      checkOutput("bp_res_amp", res_amp, 16'd11);
    end
    @(posedge clk);
    #1;
    res_ready = 1;
    waitDone(500);
    checkOutput("bp_hs", 16'(hs_count), 16'd2);

    // Best tracking with a tie on points 1 and 2.
    amp_tab[0] = 16'sd300; amp_tab[1] = 16'sd900; amp_tab[2] = 16'sd900; amp_tab[3] = -16'sd5;
    applyStimulus(16'sd1000, -16'sd7, 9'd4, 2);
    waitDone(1000);
    checkOutput("best_amp_final", best_amp, 16'd900);
    checkOutput("best_fcw_final", best_fcw, 16'd993);

    // Two's-complement wrap of the FCW, wrap on every cycle.
    applyStimulus(16'sh7FF0, 16'sh0020, 9'd2, 1);
    waitDone(200);
    checkOutput("edge_first_valid", 16'(first_valid_cyc), 16'd8);
    if (hs_fcw.size() == 2) begin
      checkOutput("edge_fcw0", hs_fcw[0], 16'h7FF0);
      checkOutput("edge_fcw1", hs_fcw[1], 16'h8010);
    end

    // Zero points: immediate done, no results.
    applyStimulus(16'sd123, 16'sd1, 9'd0, 1);
    waitDone(20);
    checkOutput("zero_done_cyc", 16'(done_cyc), 16'd1);
    checkOutput("zero_hs", 16'(hs_count), 16'd0);
    checkOutput("zero_valid", 16'(valid_seen), 16'd0);

    // start pulse during SETTLE must be ignored.
    applyStimulus(16'sd500, 16'sd25, 9'd3, 5);
    repeat (3) @(posedge clk);
    #1;
    fcw_start = 16'sd9999;
    num_points = 9'd1;
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
    waitDone(1000);
    checkOutput("ign_hs", 16'(hs_count), 16'd3);
    if (hs_fcw.size() == 3) begin
      checkOutput("ign_fcw0", hs_fcw[0], 16'd500);
      checkOutput("ign_fcw1", hs_fcw[1], 16'd525);
      checkOutput("ign_fcw2", hs_fcw[2], 16'd550);
    end

    // num_points above the maximum clamps to 256 points.
    applyStimulus(16'sd0, 16'sd3, 9'h1FF, 1);
    waitDone(4000);
    checkOutput("clamp_hs", 16'(hs_count), 16'd256);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
